dtree_feature_loader: RTL and testbench

- Upstream stage of the combinational decision-tree classifier.
- Accepts a byte-serial stream of quantised 8-bit features, one sample per frame, and assembles them into a parallel feature vector that drives the classifier inputs directly.
- Double-buffered: the next sample fills while the classifier still sees the previous one.
- Frames of the wrong length are detected and discarded.

---
 rtl/dtree_feature_loader_if.sv | 27 ++
 rtl/dtree_feature_loader.sv | 107 ++++++++++
 tb/tb_dtree_feature_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dtree_feature_loader_if.sv
// Byte-stream input and parallel feature-vector output bundle for the
// decision-tree feature loader.
interface dtree_feature_loader_if #(
  parameter int N_FEAT = 20,
  parameter int W      = 8,
  parameter int CNT_W  = 16
);
  logic                  s_valid;
  logic                  s_ready;
  logic [W-1:0]          s_data;
  logic                  s_last;
  logic [N_FEAT*W-1:0]   feat_flat;
  logic                  feat_valid;
  logic                  feat_ready;
  logic                  err_len;
  logic [CNT_W-1:0]      frame_cnt;

  modport slave (
    input  s_valid, s_data, s_last, feat_ready,
    output s_ready, feat_flat, feat_valid, err_len, frame_cnt
  );

  modport master (
    output s_valid, s_data, s_last, feat_ready,
    input  s_ready, feat_flat, feat_valid, err_len, frame_cnt
  );
endinterface

// File: rtl/dtree_feature_loader.sv
// Assembles a byte-serial feature frame into a double-buffered parallel
// vector for the decision-tree classifier; bad-length frames are discarded.
module dtree_feature_loader #(
  parameter int N_FEAT = 20,
  parameter int W      = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dtree_feature_loader_if.slave  bus
);
  localparam int IDX_W = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic [1:0] {FILL, DROP, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_FEAT*W-1:0] buf_q, buf_d;
  logic [N_FEAT*W-1:0] feat_flat_q, feat_flat_d;
  logic                feat_valid_q, feat_valid_d;
  logic                err_len_q, err_len_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                started_q;
  logic                s_ready;
  logic                accept;

  // started_q holds s_ready low for the first cycle after reset release.
  assign s_ready = started_q && (state_q != COMMIT);
  assign accept  = bus.s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    feat_flat_d  = feat_flat_q;
    feat_valid_d = feat_valid_q && !bus.feat_ready;
    err_len_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          buf_d[idx_q*W +: W] = bus.s_data;
          if (idx_q == LAST_IDX) begin
            if (bus.s_last) begin
              state_d = COMMIT;
            end else begin
              err_len_d = 1'b1;
              state_d   = DROP;
            end
          end else if (bus.s_last) begin
            err_len_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && bus.s_last) begin
          idx_d   = '0;
          state_d = FILL;
        end
      end
      COMMIT: begin
        // Loading on the same cycle the consumer takes the old sample avoids a bubble.
        if (!feat_valid_q || bus.feat_ready) begin
          feat_flat_d  = buf_q;
          feat_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 1'b1;
          idx_d        = '0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      idx_q        <= '0;
      buf_q        <= '0;
      feat_flat_q  <= '0;
      feat_valid_q <= 1'b0;
      err_len_q    <= 1'b0;
      frame_cnt_q  <= '0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      feat_flat_q  <= feat_flat_d;
      feat_valid_q <= feat_valid_d;
      err_len_q    <= err_len_d;
      frame_cnt_q  <= frame_cnt_d;
      started_q    <= 1'b1;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.feat_flat  = feat_flat_q;
  assign bus.feat_valid = feat_valid_q;
  assign bus.err_len    = err_len_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_dtree_feature_loader.sv
// Scoreboard bench for dtree_feature_loader: expected vectors are queued as
// good frames are driven and compared whenever a new sample is presented.
module tb_dtree_feature_loader;
  localparam int N_FEAT = 20;
  localparam int W      = 8;
  localparam int CNT_W  = 16;
  localparam int VW     = N_FEAT * W;

  typedef struct {
    logic [VW-1:0]    v;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtree_feature_loader_if #(.N_FEAT(N_FEAT), .W(W), .CNT_W(CNT_W)) bif ();

  dtree_feature_loader #(.N_FEAT(N_FEAT), .W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // A sample is new when valid rises or when the previous one was just taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
    end else begin
      if (bif.err_len) err_seen++;
      if (bif.feat_valid && (!prev_valid || prev_ready)) begin
        if (sb.size() == 0) begin
          chk("extra_sample", 0, 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", bif.feat_flat, e.v);
          chk("sb_cnt", VW'(bif.frame_cnt), VW'(e.c));
        end
      end
      prev_valid <= bif.feat_valid;
      prev_ready <= bif.feat_ready;
    end
  end

  function automatic logic [VW-1:0] pack(input logic [7:0] b[25]);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N_FEAT; i++) v[i*W +: W] = b[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
    int n;
    logic acc;
    if (gaps) begin
      n = 0;
      while ($urandom_range(1) == 1 && n < 8) begin
        bif.s_valid = 1'b0;
        bif.s_data  = 8'($urandom);
        bif.s_last  = 1'($urandom);
        tick();
        n++;
      end
    end
    bif.s_valid = 1'b1;
    bif.s_data  = d;
    bif.s_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bif.s_ready;
      tick();
      n++;
    end
    if (!acc) chk("byte_timeout", 0, 1);
    bif.s_valid = 1'b0;
    bif.s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[25], input int len, input bit gaps);
    for (int i = 0; i < len; i++) send_byte(b[i], (i == len - 1), gaps);
  endtask

  task automatic push_exp(input logic [7:0] b[25]);
    exp_t e;
    exp_cnt = exp_cnt + 1'b1;
    e.v = pack(b);
    e.c = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", VW'(sb.size()), 0);
  endtask

  logic [7:0] fa[25], fb[25], fr[25], fi[25];
  logic [VW-1:0] vb;
  int e0;

  initial begin
    bif.s_valid = 1'b0;
    bif.s_data = '0;
    bif.s_last = 1'b0;
    bif.feat_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      fi[i] = 8'(i);
      fa[i] = 8'hAA;
      fb[i] = 8'h55;
    end

    // Reset state
    repeat (3) tick();
    chk("rst_valid", VW'(bif.feat_valid), 0);
    chk("rst_flat", bif.feat_flat, 0);
    chk("rst_cnt", VW'(bif.frame_cnt), 0);
    chk("rst_err", VW'(bif.err_len), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_sready0", VW'(bif.s_ready), 0);
    tick();
    chk("rst_sready1", VW'(bif.s_ready), 1);

    // Incrementing frame, latency
    push_exp(fi);
    send_frame(fi, 20, 1'b0);
    chk("lat_not_yet", VW'(bif.feat_valid), 0);
    chk("commit_sready", VW'(bif.s_ready), 0);
    tick();
    chk("lat_valid", VW'(bif.feat_valid), 1);
    chk("lat_lo", VW'(bif.feat_flat[7:0]), 8'h00);
    chk("lat_hi", VW'(bif.feat_flat[159:152]), 8'h13);
    drain();

    // Back-to-back with back-pressure and same-cycle swap
    bif.feat_ready = 1'b0;
    push_exp(fa);
    send_frame(fa, 20, 1'b0);
    push_exp(fb);
    send_frame(fb, 20, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_sready", VW'(bif.s_ready), 0);
    chk("bp_hold_a", bif.feat_flat, pack(fa));
    chk("bp_valid", VW'(bif.feat_valid), 1);
    tick();
    bif.feat_ready = 1'b1;
    tick();
    chk("swap_valid", VW'(bif.feat_valid), 1);
    chk("swap_b", bif.feat_flat, pack(fb));
    chk("swap_sready", VW'(bif.s_ready), 1);
    drain();
    vb = pack(fb);

    // Short frame
    e0 = err_seen;
    send_frame(fi, 7, 1'b0);
    repeat (3) tick();
    chk("short_err", VW'(err_seen - e0), 1);
    chk("short_flat", bif.feat_flat, vb);
    chk("short_cnt", VW'(bif.frame_cnt), VW'(exp_cnt));
    for (int i = 0; i < 25; i++) fr[i] = 8'($urandom);
    push_exp(fr);
    send_frame(fr, 20, 1'b0);
    drain();

    // Long frame
    e0 = err_seen;
    send_frame(fa, 25, 1'b0);
    repeat (3) tick();
    chk("long_err", VW'(err_seen - e0), 1);
    chk("long_cnt", VW'(bif.frame_cnt), VW'(exp_cnt));
    for (int i = 0; i < 25; i++) fr[i] = 8'($urandom);
    push_exp(fr);
    send_frame(fr, 20, 1'b0);
    drain();

    // Gapped input
    push_exp(fi);
    send_frame(fi, 20, 1'b1);
    drain();

    // Reset mid-frame with a pending sample
    bif.feat_ready = 1'b0;
    push_exp(fa);
    send_frame(fa, 20, 1'b0);
    repeat (2) tick();
    drain();
    for (int i = 0; i < 10; i++) send_byte(fb[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", VW'(bif.feat_valid), 0);
    chk("mid_rst_cnt", VW'(bif.frame_cnt), 0);
    sb.delete();
    exp_cnt = '0;
    tick();
    rst_n = 1'b1;
    bif.feat_ready = 1'b1;
    tick();
    push_exp(fi);
    send_frame(fi, 20, 1'b0);
    drain();

    // Counter wrap
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    tick();
    chk("wrap_pre", VW'(bif.frame_cnt), VW'(16'hFFFF));
    exp_cnt = 16'hFFFF;
    push_exp(fb);
    send_frame(fb, 20, 1'b0);
    drain();
    chk("wrap_cnt", VW'(bif.frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
